pulse_sync_sched: RTL and testbench

PULSE_SYNC_SCHED -- requirements
Module: pulse_sync_sched

---
 rtl/pulse_sync_pkg.sv | 26 ++
 rtl/pulse_sync_sched_rr_pick.sv | 38 +++
 rtl/pulse_sync_sched.sv | 137 +++++++++++++
 tb/tb_pulse_sync_sched.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_sync_pkg.sv
// +-----------------------------------------------------------------------------
// | pulse_sync_pkg : shared types and constants for the pulse launch scheduler
// | Revision 1.0 : initial release
// +-----------------------------------------------------------------------------
`default_nettype none

package pulse_sync_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LAUNCH  = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_t;

  localparam int DEF_N_REQ  = 4;
  localparam int DEF_GAP    = 4;
  localparam int DROP_CNT_W = 8;

  // Index reached by stepping off positions forward from start on an n-entry ring.
  function automatic int rr_idx(input int start, input int off, input int n);
    return (start + off) % n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pulse_sync_sched_rr_pick.sv
// +-----------------------------------------------------------------------------
// | rr_pick : combinational round-robin winner search over a pending vector
// | Revision 1.0 : initial release
// +-----------------------------------------------------------------------------
`default_nettype none

module rr_pick
  import pulse_sync_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ
) (
  input  logic [N_REQ-1:0]         pend,
  input  logic [$clog2(N_REQ)-1:0] start,
  output logic [$clog2(N_REQ)-1:0] winner,
  output logic                     valid
);

  localparam int IW = $clog2(N_REQ);

  logic [IW-1:0] idx;

  // Walk from the farthest offset down so the nearest pending entry lands last.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = IW'(rr_idx(int'(start), i, N_REQ));
      if (pend[idx]) begin
        winner = idx;
        valid  = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/pulse_sync_sched.sv
// +-----------------------------------------------------------------------------
// | pulse_sync_sched : round-robin launcher of GAP-spaced pulses into a toggle
// | synchronizer. PULSE_SYNC_SCHED_DROP_CNT_EN adds the saturating drop_cnt port.
// | Revision 1.0 : initial release
// +-----------------------------------------------------------------------------
`default_nettype none

module pulse_sync_sched
  import pulse_sync_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int GAP   = DEF_GAP
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  output logic                     pulse_out,
  output logic [$clog2(N_REQ)-1:0] chan_id,
  output logic [N_REQ-1:0]         ack,
  output logic [N_REQ-1:0]         pend,
`ifdef PULSE_SYNC_SCHED_DROP_CNT_EN
  output logic [DROP_CNT_W-1:0]    drop_cnt,
`endif
  output logic                     drop_err
);

  localparam int IW    = $clog2(N_REQ);
  localparam int CNT_W = 8;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [IW-1:0]      chan_q, chan_d;
  logic [N_REQ-1:0]   pend_q, pend_d;
  logic [N_REQ-1:0]   ack_q, ack_d;
  logic               pulse_q, pulse_d;
  logic               drop_q, drop_d;
  logic [N_REQ-1:0]   clr;
  logic [IW-1:0]      pick;
  logic               pick_valid;
  logic               launch;

  rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
    .pend   (pend_q),
    .start  (ptr_q),
    .winner (pick),
    .valid  (pick_valid)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    chan_d  = chan_q;
    ack_d   = '0;
    pulse_d = 1'b0;
    launch  = 1'b0;
    // ack_q is the one-hot winner, so it doubles as the clear mask on LAUNCH exit.
    clr     = (state_q == ST_LAUNCH) ? ack_q : '0;
    pend_d  = (pend_q & ~clr) | req;
    drop_d  = |(req & pend_q & ~clr);

    case (state_q)
      ST_IDLE: begin
        if (pick_valid) launch = 1'b1;
      end
      ST_LAUNCH: begin
        state_d = ST_HOLDOFF;
        cnt_d   = CNT_W'(GAP - 1);
      end
      ST_HOLDOFF: begin
        if (cnt_q == '0) begin
          if (pick_valid) launch = 1'b1;
          else            state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (launch) begin
      state_d = ST_LAUNCH;
      pulse_d = 1'b1;
      ack_d   = N_REQ'(1) << pick;
      chan_d  = pick;
      ptr_d   = (pick == IW'(N_REQ - 1)) ? '0 : pick + IW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      chan_q  <= '0;
      pend_q  <= '0;
      ack_q   <= '0;
      pulse_q <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      chan_q  <= chan_d;
      pend_q  <= pend_d;
      ack_q   <= ack_d;
      pulse_q <= pulse_d;
      drop_q  <= drop_d;
    end
  end

`ifdef PULSE_SYNC_SCHED_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop_q && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) drop_cnt_q <= '0;
    else       drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`endif

  assign pulse_out = pulse_q;
  assign chan_id   = chan_q;
  assign ack       = ack_q;
  assign pend      = pend_q;
  assign drop_err  = drop_q;

endmodule

`default_nettype wire

// File: tb/tb_pulse_sync_sched.sv
// +-----------------------------------------------------------------------------
// | tb_pulse_sync_sched : directed self-checking bench for pulse_sync_sched
// | Revision 1.0 : initial release
// +-----------------------------------------------------------------------------
`default_nettype none

module tb_pulse_sync_sched;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic       pulse_out;
  logic [1:0] chan_id;
  logic [3:0] ack;
  logic [3:0] pend;
  logic       drop_err;
`ifdef PULSE_SYNC_SCHED_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pulse_sync_sched #(.N_REQ(4), .GAP(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .pulse_out (pulse_out),
    .chan_id   (chan_id),
    .ack       (ack),
    .pend      (pend),
`ifdef PULSE_SYNC_SCHED_DROP_CNT_EN
    .drop_cnt  (drop_cnt),
`endif
    .drop_err  (drop_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_pulse"}, 32'(pulse_out), 32'd0);
    chk({tag, "_ack"},   32'(ack),       32'd0);
    chk({tag, "_chan"},  32'(chan_id),   32'd0);
    chk({tag, "_pend"},  32'(pend),      32'd0);
    chk({tag, "_drop"},  32'(drop_err),  32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic expect_launch(input string tag, input int k);
    chk({tag, "_pulse"}, 32'(pulse_out), 32'd1);
    chk({tag, "_ack"},   32'(ack),       32'(4'b0001 << k));
    chk({tag, "_chan"},  32'(chan_id),   32'(k));
  endtask

  // Four low cycles after a launch, then the next launch for requester k.
  task automatic expect_gap_then(input string tag, input int k);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk({tag, "_gap_low"}, 32'(pulse_out), 32'd0);
    end
    tick();
    expect_launch(tag, k);
  endtask

  task automatic settle();
    repeat (6) tick();
  endtask

  initial begin
    bit seen3;
    int launches;

    reset = 1'b1;
    req   = '0;
    tick();
    tick();
    chk_quiet("rst");
    reset = 1'b0;
    tick();
    chk_quiet("post_rst");

    // Single request: two edges to pulse_out
    req = 4'b0001;
    tick();
    chk("single_pend", 32'(pend), 32'h1);
    chk("single_nopulse", 32'(pulse_out), 32'd0);
    req = '0;
    tick();
    expect_launch("single", 0);
    tick();
    chk("single_end_pulse", 32'(pulse_out), 32'd0);
    chk("single_end_pend", 32'(pend), 32'd0);
    chk("single_chan_held", 32'(chan_id), 32'd0);
    settle();

    // All four at once from a fresh pointer
    do_reset();
    req = 4'b1111;
    tick();
    chk("all_pend", 32'(pend), 32'hF);
    req = '0;
    tick();
    expect_launch("all0", 0);
    expect_gap_then("all1", 1);
    expect_gap_then("all2", 2);
    expect_gap_then("all3", 3);
    tick();
    chk("all_pend_clr", 32'(pend), 32'd0);
    settle();
    chk("all_idle", 32'(pulse_out), 32'd0);

    // Coalescing during HOLDOFF
    do_reset();
    req = 4'b0001;
    tick();
    req = '0;
    tick();
    expect_launch("coal_first", 0);
    tick();
    req = 4'b0100;
    tick();
    chk("coal_pend", 32'(pend), 32'h4);
    chk("coal_nodrop1", 32'(drop_err), 32'd0);
    req = '0;
    tick();
    req = 4'b0100;
    tick();
    chk("coal_drop", 32'(drop_err), 32'd1);
    chk("coal_pend2", 32'(pend), 32'h4);
    req = '0;
    tick();
    chk("coal_drop_once", 32'(drop_err), 32'd0);
    expect_launch("coal_launch", 2);
`ifdef PULSE_SYNC_SCHED_DROP_CNT_EN
    chk("coal_drop_cnt", 32'(drop_cnt), 32'd1);
`endif
    tick();
    chk("coal_pend_clr", 32'(pend), 32'd0);
    settle();
    chk("coal_one_launch", 32'(pulse_out), 32'd0);

    // Set wins over the LAUNCH-exit clear; pointer is 3 here
    req = 4'b0010;
    tick();
    req = '0;
    tick();
    expect_launch("sw_first", 1);
    req = 4'b0010;
    tick();
    req = '0;
    chk("sw_pend", 32'(pend), 32'h2);
    chk("sw_nodrop", 32'(drop_err), 32'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("sw_gap_low", 32'(pulse_out), 32'd0);
      chk("sw_gap_nodrop", 32'(drop_err), 32'd0);
    end
    tick();
    expect_launch("sw_second", 1);
    settle();

    // Asynchronous reset in HOLDOFF with pend=0110
    req = 4'b0001;
    tick();
    req = '0;
    tick();
    expect_launch("rh_first", 0);
    tick();
    req = 4'b0110;
    tick();
    req = '0;
    chk("rh_pend", 32'(pend), 32'h6);
    #2;
    reset = 1'b1;
    #1;
    chk_quiet("rh_async");
    tick();
    tick();
    reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("rh_no_pulse", 32'(pulse_out), 32'd0);
    end
    chk("rh_pend_final", 32'(pend), 32'd0);

    // Fairness: req[0] held, single req[3] pulse
    req = 4'b0001;
    tick();
    tick();
    expect_launch("fair_first", 0);
    req = 4'b1001;
    tick();
    chk("fair_pend", 32'(pend), 32'h9);
    req = 4'b0001;
    seen3    = 1'b0;
    launches = 0;
    for (int c = 0; c < 30 && launches < 2; c++) begin
      tick();
      if (pulse_out) begin
        launches++;
        if (chan_id == 2'd3) seen3 = 1'b1;
      end
    end
    chk("fair_launches", 32'(launches), 32'd2);
    chk("fair_r3_served", 32'(seen3), 32'd1);
    req = '0;
    settle();
    settle();
    chk("fair_idle", 32'(pulse_out), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
